neureka_normquant_ctrl: RTL and testbench

//  Sequences one bank of neureka_normquant_shifter lanes (OUTPUT_REGISTER=1) over a job of
//  LEN accumulator rows. It accepts a job descriptor via valid/ready, then reads rows
//  0..LEN-1 from the accumulator buffer and pulses the shifter start.
//  It presents each quantized row downstream with valid/ready/last and backpressure.
//  It sits between the accumulator buffer and the streamer output path.

---
 rtl/neureka_normquant_ctrl_if.sv | 46 ++++
 rtl/neureka_normquant_ctrl.sv | 138 +++++++++++++
 tb/tb_neureka_normquant_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/neureka_normquant_ctrl_if.sv
// Handshake and bus bundle between the normquant controller and its neighbours:
// job descriptor in, accumulator buffer read port, shifter lane control, and
// the quantized row stream out.
// Quant mode encoding on cfg_mode / nq_ctrl.quant_mode: 0 = 8b, 1 = 16b, 2 = 32b.
interface neureka_normquant_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int LEN_W  = 6
);
   typedef struct packed {
      logic       start;
      logic       relu;
      logic [1:0] quant_mode;
      logic       use_shifting;
   } ctrl_normquant_t;

   logic              cfg_valid;
   logic              cfg_ready;
   logic [LEN_W-1:0]  cfg_len;
   logic [7:0]        cfg_shift;
   logic [1:0]        cfg_mode;
   logic              cfg_relu;
   logic              cfg_use_shift;

   logic              buf_rd_en;
   logic [ADDR_W-1:0] buf_rd_addr;

   ctrl_normquant_t   nq_ctrl;
   logic [7:0]        nq_shift;
   logic              nq_clear;

   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   // controller view
   modport master (
      input  cfg_valid, cfg_len, cfg_shift, cfg_mode, cfg_relu, cfg_use_shift, out_ready,
      output cfg_ready, buf_rd_en, buf_rd_addr, nq_ctrl, nq_shift, nq_clear, out_valid, out_last
   );

   // environment view
   modport slave (
      output cfg_valid, cfg_len, cfg_shift, cfg_mode, cfg_relu, cfg_use_shift, out_ready,
      input  cfg_ready, buf_rd_en, buf_rd_addr, nq_ctrl, nq_shift, nq_clear, out_valid, out_last
   );
endinterface

// File: rtl/neureka_normquant_ctrl.sv
// Sequences one bank of normquant shifter lanes over a job of LEN accumulator
// rows: read strobe (S0) -> lane start (S1) -> output row valid (S2), with the
// whole pipeline frozen while the downstream stalls.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a job descriptor; cfg_ready high
// RUN   | issuing buffer reads and streaming rows until the last is taken
// DONE  | one-cycle completion pulse on done_o, then back to IDLE
module neureka_normquant_ctrl #(
   parameter int ADDR_W = 5,
   parameter int LEN_W  = 6
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   neureka_normquant_ctrl_if.master bus,
   output logic                    busy_o,
   output logic                    done_o
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [7:0]       shift_q, shift_d;
   logic [1:0]       mode_q, mode_d;
   logic             relu_q, relu_d;
   logic             use_shift_q, use_shift_d;
   logic [LEN_W-1:0] issued_q, issued_d;
   logic [LEN_W-1:0] s1_idx_q, s1_idx_d;
   logic             s1_v_q, s1_v_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             en;
   logic             rd_en;

   // Next-state, config latch and pipeline advance; clear overrides everything.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      shift_d     = shift_q;
      mode_d      = mode_q;
      relu_d      = relu_q;
      use_shift_d = use_shift_q;
      issued_d    = issued_q;
      s1_idx_d    = s1_idx_q;
      s1_v_d      = s1_v_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      en    = ~(out_valid_q & ~bus.out_ready);
      rd_en = (state_q == ST_RUN) & en & (issued_q < len_q) & ~clear_i;

      case (state_q)
         ST_IDLE: begin
            if (bus.cfg_valid) begin
               len_d       = bus.cfg_len;
               // lanes only take a 6-bit shift; anything beyond 32 saturates
               shift_d     = (bus.cfg_shift > 8'd32) ? 8'd32 : bus.cfg_shift;
               mode_d      = bus.cfg_mode;
               relu_d      = bus.cfg_relu;
               use_shift_d = bus.cfg_use_shift;
               issued_d    = '0;
               state_d     = (bus.cfg_len != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (out_valid_q & bus.out_ready & out_last_q) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (en) begin
         s1_v_d      = rd_en;
         s1_idx_d    = issued_q;
         out_valid_d = s1_v_q;
         out_last_d  = s1_v_q & (s1_idx_q == len_q - LEN_ONE);
         if (rd_en) issued_d = issued_q + LEN_ONE;
      end

      if (clear_i) begin
         state_d     = ST_IDLE;
         issued_d    = '0;
         s1_v_d      = 1'b0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   // State, latched config and pipeline registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         shift_q     <= '0;
         mode_q      <= '0;
         relu_q      <= 1'b0;
         use_shift_q <= 1'b0;
         issued_q    <= '0;
         s1_idx_q    <= '0;
         s1_v_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         shift_q     <= shift_d;
         mode_q      <= mode_d;
         relu_q      <= relu_d;
         use_shift_q <= use_shift_d;
         issued_q    <= issued_d;
         s1_idx_q    <= s1_idx_d;
         s1_v_q      <= s1_v_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // Outputs; a clear cycle neither accepts a job nor reports completion.
   always_comb begin
      bus.cfg_ready             = (state_q == ST_IDLE) & ~clear_i;
      bus.buf_rd_en             = rd_en;
      bus.buf_rd_addr           = issued_q[ADDR_W-1:0];
      bus.nq_ctrl.start         = s1_v_q & en & ~clear_i;
      bus.nq_ctrl.relu          = relu_q;
      bus.nq_ctrl.quant_mode    = mode_q;
      bus.nq_ctrl.use_shifting  = use_shift_q;
      bus.nq_shift              = shift_q;
      bus.nq_clear              = clear_i;
      bus.out_valid             = out_valid_q;
      bus.out_last              = out_last_q;
      busy_o                    = (state_q != ST_IDLE);
      done_o                    = (state_q == ST_DONE) & ~clear_i;
   end
endmodule

// File: tb/tb_neureka_normquant_ctrl.sv
// Directed bench for neureka_normquant_ctrl: a table of jobs run through a
// per-cycle monitor, plus hand sequences for clear and mid-job reset.
module tb_neureka_normquant_ctrl;
   localparam int ADDR_W = 5;
   localparam int LEN_W  = 6;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   logic busy;
   logic done;

   neureka_normquant_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   neureka_normquant_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .bus     (bus.master),
      .busy_o  (busy),
      .done_o  (done)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int len;
      int shift;
      int mode;
      bit relu;
      bit use_shift;
      int pat;        // 0: ready always, 1: ready 1,0,0 repeating, 2: ready 0,1 repeating
      int exp_shift;
   } vec_t;

   vec_t vecs[6];

   function automatic bit ready_of(input int pat, input int k);
      case (pat)
         1:       return (k % 3) == 0;
         2:       return (k % 2) == 1;
         default: return 1'b1;
      endcase
   endfunction

   task automatic set_cfg(input int len, input int shift, input int mode, input bit relu, input bit us);
      bus.cfg_len       = LEN_W'(len);
      bus.cfg_shift     = 8'(shift);
      bus.cfg_mode      = 2'(mode);
      bus.cfg_relu      = relu;
      bus.cfg_use_shift = us;
   endtask

   task automatic run_job(input vec_t v);
      int strobes = 0, starts = 0, accepted = 0, dones = 0;
      int stall_err = 0, order_err = 0, last_err = 0, cfg_err = 0;
      int first_strobe = -1, first_valid = -1, last_acc_k = -1, done_k = -1;
      bit stall;
      @(negedge clk);
      bus.cfg_valid = 1'b1;
      bus.out_ready = 1'b1;
      set_cfg(v.len, v.shift, v.mode, v.relu, v.use_shift);
      #1 check("cfg_ready_idle", bus.cfg_ready, 1);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         // a second descriptor offered mid-job must be ignored
         bus.cfg_valid = (k == 0) && (v.len > 0);
         set_cfg(3, 0, 3, ~v.relu, ~v.use_shift);
         bus.out_ready = ready_of(v.pat, k);
         #1;
         if (k == 0 && v.len > 0) check("cfg_ignored_busy", bus.cfg_ready, 0);
         stall = bus.out_valid && !bus.out_ready;
         if (stall && (bus.buf_rd_en || bus.nq_ctrl.start)) stall_err++;
         if (bus.buf_rd_en) begin
            if (int'(bus.buf_rd_addr) != strobes) order_err++;
            if (first_strobe < 0) first_strobe = k;
            strobes++;
         end
         if (bus.nq_ctrl.start) starts++;
         if (bus.out_valid && bus.out_ready) begin
            if (bus.out_last !== (accepted == v.len - 1)) last_err++;
            if (first_valid < 0) first_valid = k;
            accepted++;
            last_acc_k = k;
         end
         if (busy && (int'(bus.nq_shift) != v.exp_shift || int'(bus.nq_ctrl.quant_mode) != v.mode ||
                      bus.nq_ctrl.relu !== v.relu || bus.nq_ctrl.use_shifting !== v.use_shift))
            cfg_err++;
         if (done) begin
            dones++;
            done_k = k;
            break;
         end
      end
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("post_done_busy", busy, 0);
      check("post_done_pulse", done, 0);
      check("post_done_cfg_ready", bus.cfg_ready, 1);
      check("strobe_count", strobes, v.len);
      check("start_count", starts, v.len);
      check("accepted_rows", accepted, v.len);
      check("addr_order_errs", order_err, 0);
      check("last_errs", last_err, 0);
      check("stall_activity", stall_err, 0);
      check("cfg_hold_errs", cfg_err, 0);
      check("done_count", dones, 1);
      check("done_timing", done_k, (v.len > 0) ? last_acc_k + 1 : 0);
      if (v.pat == 0 && v.len > 0) begin
         check("strobe_to_valid", first_valid - first_strobe, 2);
         check("throughput", last_acc_k - first_valid, v.len - 1);
      end
   endtask

   initial begin
      vecs[0] = '{len: 4,  shift: 4,  mode: 0, relu: 0, use_shift: 1, pat: 0, exp_shift: 4};
      vecs[1] = '{len: 6,  shift: 7,  mode: 1, relu: 1, use_shift: 1, pat: 1, exp_shift: 7};
      vecs[2] = '{len: 0,  shift: 3,  mode: 0, relu: 0, use_shift: 0, pat: 0, exp_shift: 3};
      vecs[3] = '{len: 5,  shift: 40, mode: 2, relu: 1, use_shift: 1, pat: 0, exp_shift: 32};
      vecs[4] = '{len: 32, shift: 33, mode: 1, relu: 0, use_shift: 1, pat: 0, exp_shift: 32};
      vecs[5] = '{len: 1,  shift: 32, mode: 2, relu: 1, use_shift: 0, pat: 2, exp_shift: 32};

      rst   = 1'b1;
      clear = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.out_ready = 1'b1;
      set_cfg(0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_cfg_ready", bus.cfg_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", bus.buf_rd_en, 0);
      check("rst_rd_addr", bus.buf_rd_addr, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_nq_shift", bus.nq_shift, 0);
      check("rst_nq_ctrl", bus.nq_ctrl, 0);
      rst = 1'b0;

      foreach (vecs[i]) run_job(vecs[i]);

      // clear in the third cycle of a LEN=8 job
      begin
         int late_done = 0, late_rd = 0;
         @(negedge clk);
         bus.cfg_valid = 1'b1;
         set_cfg(8, 4, 0, 0, 1);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.cfg_valid = 1'b0;
            clear = (k == 2);
         end
         #1;
         check("clear_nq_clear", bus.nq_clear, 1);
         check("clear_no_done", done, 0);
         @(negedge clk);
         clear = 1'b0;
         #1;
         check("clear_out_valid", bus.out_valid, 0);
         check("clear_busy", busy, 0);
         check("clear_nq_clear_drop", bus.nq_clear, 0);
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (done) late_done++;
            if (bus.buf_rd_en) late_rd++;
         end
         check("clear_late_done", late_done, 0);
         check("clear_late_rd", late_rd, 0);
      end
      run_job('{len: 2, shift: 5, mode: 0, relu: 0, use_shift: 1, pat: 0, exp_shift: 5});

      // clear together with a descriptor: the job is not taken
      @(negedge clk);
      bus.cfg_valid = 1'b1;
      clear = 1'b1;
      set_cfg(3, 1, 0, 0, 1);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      clear = 1'b0;
      #1;
      check("clear_with_cfg_busy", busy, 0);
      check("clear_with_cfg_rd_en", bus.buf_rd_en, 0);

      // asynchronous reset between edges in the middle of a job
      @(negedge clk);
      bus.cfg_valid = 1'b1;
      set_cfg(8, 9, 1, 1, 1);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_out_valid", bus.out_valid, 0);
      check("arst_rd_en", bus.buf_rd_en, 0);
      check("arst_nq_shift", bus.nq_shift, 0);
      check("arst_cfg_ready", bus.cfg_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("arst_release_cfg_ready", bus.cfg_ready, 1);
      check("arst_release_busy", busy, 0);
      run_job('{len: 3, shift: 2, mode: 1, relu: 0, use_shift: 1, pat: 1, exp_shift: 2});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
